// File: rtl/adder_pipe_if.sv
// Operand/result handshake bundle for adder_pipe: valid/ready on both the input side and the output side.
interface adder_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic             sub;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             cout;
  logic             overflow;
  logic             zero;

  modport master (
    output in_valid, data_operandA, data_operandB, sub, cin, out_ready,
    input  in_ready, out_valid, out, cout, overflow, zero
  );

  modport slave (
    input  in_valid, data_operandA, data_operandB, sub, cin, out_ready,
    output in_ready, out_valid, out, cout, overflow, zero
  );
endinterface

// File: rtl/adder_pipe.sv
// Pipelined carry-lookahead add/sub, one GROUP-bit lookahead group per stage, latency WIDTH/GROUP cycles.
// A stalled output freezes every stage (no bubble compression); in_ready = !out_valid || out_ready.
module adder_pipe #(
  parameter int WIDTH = 32,
  parameter int GROUP = 8
) (
  input logic         clock,
  input logic         reset,
  adder_pipe_if.slave io
);
  localparam int NG = WIDTH / GROUP;

  logic w_adv;

  for (genvar k = 0; k < NG; k++) begin : g_stage
    localparam int HI = WIDTH - (k + 1) * GROUP;
    localparam int SW = (k + 1) * GROUP;

    logic [HI+GROUP-1:0] w_a;
    logic [HI+GROUP-1:0] w_b;
    logic [SW-1:0]       w_s_nxt;
    logic                w_v_in;
    logic                w_c_in;
    logic [GROUP-1:0]    w_g;
    logic [GROUP-1:0]    w_p;
    logic [GROUP-1:0]    w_sum;
    logic                w_gg;
    logic                w_gp;
    logic                w_rc;
    logic                w_cout;
    logic                r_vld;
    logic                r_c;
    logic [SW-1:0]       r_s;

    if (k == 0) begin : g_in
      assign w_v_in  = io.in_valid;
      assign w_a     = io.data_operandA;
      assign w_b     = io.sub ? ~io.data_operandB : io.data_operandB;
      assign w_c_in  = io.sub | io.cin;
      assign w_s_nxt = w_sum;
    end else begin : g_in
      assign w_v_in  = g_stage[k-1].r_vld;
      assign w_a     = g_stage[k-1].g_skew.r_a;
      assign w_b     = g_stage[k-1].g_skew.r_b;
      assign w_c_in  = g_stage[k-1].r_c;
      assign w_s_nxt = {w_sum, g_stage[k-1].r_s};
    end

    assign w_g = w_a[GROUP-1:0] & w_b[GROUP-1:0];
    assign w_p = w_a[GROUP-1:0] | w_b[GROUP-1:0];

    // w_rc supplies the in-group carries for the sum bits; the group carry out uses G + P*c_in
    always_comb begin
      w_gg  = 1'b0;
      w_gp  = 1'b1;
      w_rc  = w_c_in;
      w_sum = '0;
      for (int i = 0; i < GROUP; i++) begin
        w_sum[i] = w_a[i] ^ w_b[i] ^ w_rc;
        w_rc     = w_g[i] | (w_p[i] & w_rc);
        w_gg     = w_g[i] | (w_p[i] & w_gg);
        w_gp     = w_gp & w_p[i];
      end
    end

    assign w_cout = w_gg | (w_gp & w_c_in);

    always_ff @(posedge clock) begin
      if (reset) begin
        r_vld <= 1'b0;
        r_c   <= 1'b0;
        r_s   <= '0;
      end else if (w_adv) begin
        r_vld <= w_v_in;
        r_c   <= w_cout;
        r_s   <= w_s_nxt;
      end
    end

    if (HI > 0) begin : g_skew
      logic [HI-1:0] r_a;
      logic [HI-1:0] r_b;

      always_ff @(posedge clock) begin
        if (reset) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_adv) begin
          r_a <= w_a[HI+GROUP-1:GROUP];
          r_b <= w_b[HI+GROUP-1:GROUP];
        end
      end
    end else begin : g_last
      logic r_ovf;
      logic r_zero;

      always_ff @(posedge clock) begin
        if (reset) begin
          r_ovf  <= 1'b0;
          r_zero <= 1'b0;
        end else if (w_adv) begin
          r_ovf  <= (w_a[GROUP-1] == w_b[GROUP-1]) && (w_sum[GROUP-1] != w_a[GROUP-1]);
          r_zero <= ~|w_s_nxt;
        end
      end
    end
  end

  assign w_adv        = !g_stage[NG-1].r_vld || io.out_ready;
  assign io.in_ready  = w_adv && !reset;
  assign io.out_valid = g_stage[NG-1].r_vld;
  assign io.out       = g_stage[NG-1].r_s;
  assign io.cout      = g_stage[NG-1].r_c;
  assign io.overflow  = g_stage[NG-1].g_last.r_ovf;
  assign io.zero      = g_stage[NG-1].g_last.r_zero;
endmodule

// File: tb/tb_adder_pipe.sv
// Directed bench for adder_pipe: arithmetic scoreboard with a latency/stall queue, plus literal spot checks.
module tb_adder_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  adder_pipe_if #(.WIDTH(32)) b32 ();
  adder_pipe_if #(.WIDTH(16)) b16 ();

  adder_pipe #(.WIDTH(32), .GROUP(8)) u_dut   (.clock(clk), .reset(rst), .io(b32));
  adder_pipe #(.WIDTH(16), .GROUP(4)) u_dut16 (.clock(clk), .reset(rst), .io(b16));

  typedef struct packed {
    logic [31:0] s;
    logic        c;
    logic        v;
    logic        z;
  } res_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  res_t m_res [4];
  logic m_vld [4];
  logic [31:0] got_q [$];
  int          got_cyc [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic res_t calc(input logic [31:0] a, input logic [31:0] b, input logic s, input logic c);
    logic [31:0] bp;
    logic [32:0] t;
    res_t        r;
    bp  = s ? ~b : b;
    t   = {1'b0, a} + {1'b0, bp} + {32'b0, (s ? 1'b1 : c)};
    r.s = t[31:0];
    r.c = t[32];
    r.v = (a[31] == bp[31]) && (t[31] != a[31]);
    r.z = (t[31:0] == 32'h0);
    return r;
  endfunction

  // Reference: four-deep latency line that shifts only when the output is free or being taken
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        m_vld[i] = 1'b0;
        m_res[i] = '0;
      end
    end else if (!m_vld[3] || b32.out_ready) begin
      for (int i = 3; i > 0; i--) begin
        m_vld[i] = m_vld[i-1];
        m_res[i] = m_res[i-1];
      end
      m_vld[0] = b32.in_valid;
      m_res[0] = calc(b32.data_operandA, b32.data_operandB, b32.sub, b32.cin);
    end
  end

  always @(negedge clk) begin
    chk("cmp in_ready", 32'(b32.in_ready), 32'(!rst && (!m_vld[3] || b32.out_ready)));
    chk("cmp out_valid", 32'(b32.out_valid), 32'(m_vld[3]));
    if (m_vld[3]) begin
      chk("cmp out", b32.out, m_res[3].s);
      chk("cmp cout", 32'(b32.cout), 32'(m_res[3].c));
      chk("cmp overflow", 32'(b32.overflow), 32'(m_res[3].v));
      chk("cmp zero", 32'(b32.zero), 32'(m_res[3].z));
    end
    if (!rst && b32.out_valid && b32.out_ready) begin
      got_q.push_back(b32.out);
      got_cyc.push_back(cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s, input logic c);
    b32.in_valid      = 1'b1;
    b32.data_operandA = a;
    b32.data_operandB = b;
    b32.sub           = s;
    b32.cin           = c;
  endtask

  task automatic idle();
    b32.in_valid = 1'b0;
  endtask

  logic [31:0] h_out;
  logic        h_c;
  int          c0;

  initial begin
    for (int i = 0; i < 4; i++) begin
      m_vld[i] = 1'b0;
      m_res[i] = '0;
    end
    b32.in_valid = 1'b0; b32.data_operandA = '0; b32.data_operandB = '0;
    b32.sub = 1'b0; b32.cin = 1'b0; b32.out_ready = 1'b1;
    b16.in_valid = 1'b0; b16.data_operandA = '0; b16.data_operandB = '0;
    b16.sub = 1'b0; b16.cin = 1'b0; b16.out_ready = 1'b1;

    // reset state
    tick(); tick();
    chk("rst in_ready", 32'(b32.in_ready), 32'h0);
    chk("rst out_valid", 32'(b32.out_valid), 32'h0);
    chk("rst out", b32.out, 32'h0);
    chk("rst flags", {29'b0, b32.cout, b32.overflow, b32.zero}, 32'h0);
    chk("rst out_valid16", 32'(b16.out_valid), 32'h0);
    rst = 1'b0;

    // signed overflow
    send(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0); tick(); idle(); tick(); tick(); tick();
    chk("ovf out_valid", 32'(b32.out_valid), 32'h1);
    chk("ovf out", b32.out, 32'h8000_0000);
    chk("ovf cout", 32'(b32.cout), 32'h0);
    chk("ovf overflow", 32'(b32.overflow), 32'h1);
    chk("ovf zero", 32'(b32.zero), 32'h0);
    tick();

    // subtract with and without borrow; cin ignored in sub mode
    send(32'd5, 32'd7, 1'b1, 1'b0); tick();
    send(32'd7, 32'd5, 1'b1, 1'b1); tick();
    send(32'h8000_0000, 32'h1, 1'b1, 1'b0); tick();
    idle(); tick();
    chk("sub57 out", b32.out, 32'hFFFF_FFFE);
    chk("sub57 cout", 32'(b32.cout), 32'h0);
    chk("sub57 overflow", 32'(b32.overflow), 32'h0);
    tick();
    chk("sub75 out", b32.out, 32'h2);
    chk("sub75 cout", 32'(b32.cout), 32'h1);
    chk("sub75 overflow", 32'(b32.overflow), 32'h0);
    tick();
    chk("submin out", b32.out, 32'h7FFF_FFFF);
    chk("submin cout", 32'(b32.cout), 32'h1);
    chk("submin overflow", 32'(b32.overflow), 32'h1);
    tick();

    // carry ripples across every group, both geometries
    send(32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1);
    b16.in_valid = 1'b1; b16.data_operandA = 16'hFFFF; b16.data_operandB = 16'h0;
    b16.sub = 1'b0; b16.cin = 1'b1;
    tick(); idle(); b16.in_valid = 1'b0; tick(); tick(); tick();
    chk("carry out", b32.out, 32'h0);
    chk("carry cout", 32'(b32.cout), 32'h1);
    chk("carry zero", 32'(b32.zero), 32'h1);
    chk("carry overflow", 32'(b32.overflow), 32'h0);
    chk("carry16 out_valid", 32'(b16.out_valid), 32'h1);
    chk("carry16 out", 32'(b16.out), 32'h0);
    chk("carry16 cout", 32'(b16.cout), 32'h1);
    chk("carry16 zero", 32'(b16.zero), 32'h1);
    tick();

    // back-to-back throughput
    got_q.delete(); got_cyc.delete();
    c0 = cyc;
    for (int i = 1; i <= 6; i++) begin
      send(32'(i), 32'(i), 1'b0, 1'b0);
      chk("b2b in_ready", 32'(b32.in_ready), 32'h1);
      tick();
    end
    idle(); tick(); tick(); tick(); tick();
    chk("b2b count", 32'(got_q.size()), 32'd6);
    for (int i = 0; i < got_q.size() && i < 6; i++) begin
      chk("b2b value", got_q[i], 32'(2 * (i + 1)));
      chk("b2b cycle", 32'(got_cyc[i]), 32'(c0 + 4 + i));
    end

    // backpressure: 3 stalled cycles with results queued behind
    got_q.delete(); got_cyc.delete();
    send(32'd100, 32'd1, 1'b0, 1'b0); tick();
    send(32'd200, 32'd2, 1'b0, 1'b0); tick();
    send(32'd300, 32'd3, 1'b0, 1'b0); tick();
    idle(); tick();
    b32.out_ready = 1'b0;
    h_out = b32.out;
    h_c   = b32.cout;
    chk("bp first", h_out, 32'd101);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp in_ready", 32'(b32.in_ready), 32'h0);
      chk("bp out_valid", 32'(b32.out_valid), 32'h1);
      chk("bp hold out", b32.out, h_out);
      chk("bp hold cout", 32'(b32.cout), 32'(h_c));
    end
    b32.out_ready = 1'b1;
    tick(); tick(); tick(); tick();
    chk("bp count", 32'(got_q.size()), 32'd3);
    for (int i = 0; i < got_q.size() && i < 3; i++)
      chk("bp order", got_q[i], 32'(101 * (i + 1)));

    // reset with two operations in flight
    send(32'd1, 32'd1, 1'b0, 1'b0); tick();
    send(32'd2, 32'd2, 1'b0, 1'b0); tick();
    idle(); rst = 1'b1; #1;
    chk("midrst in_ready", 32'(b32.in_ready), 32'h0);
    tick();
    rst = 1'b0;
    chk("midrst out", b32.out, 32'h0);
    for (int i = 0; i < 6; i++) begin
      chk("midrst out_valid", 32'(b32.out_valid), 32'h0);
      tick();
    end
    send(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0); tick(); idle(); tick(); tick(); tick();
    chk("postrst out_valid", 32'(b32.out_valid), 32'h1);
    chk("postrst out", b32.out, 32'h2345_6789);
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
